// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
// Feeds a configuration bitstream into a serial chain of scan flip-flops.
// Words arrive on a valid/ready port, are serialised LSB-first onto the
// chain's scan input, and the chain clock enable is pulsed so that exactly
// CHAIN_LEN shifts happen per load. Bits of the last word beyond the chain
// length are dropped. The chain's own reset/set pins are never touched.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              chain_en,
    output logic              chain_se,
    output logic              chain_si,
    output logic              busy,
    output logic              done
);

    // remaining counts 0..CHAIN_LEN, the per-word count 0..WORD_W
    localparam int REM_W = $clog2(CHAIN_LEN + 1);
    localparam int CNT_W = $clog2(WORD_W + 1);

    localparam logic [REM_W-1:0] REM_FULL   = REM_W'(CHAIN_LEN);
    localparam logic [REM_W-1:0] REM_ONE    = REM_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_WORD   = CNT_W'(WORD_W);
    localparam int unsigned      WORD_W_U   = WORD_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_e;

    // Output flags held in flops; each is a pure function of the state
    // being entered, so they change exactly on the state edge.
    typedef struct packed {
        logic ready;
        logic en;
        logic busy;
        logic done;
    } outs_t;

    function automatic outs_t decode_outs(input state_e s);
        outs_t o;
        o = '0;
        case (s)
            S_LOAD: begin
                o.ready = 1'b1;
                o.busy  = 1'b1;
            end
            S_SHIFT: begin
                o.en   = 1'b1;
                o.busy = 1'b1;
            end
            S_DONE: begin
                o.done = 1'b1;
            end
            default: begin
                o = '0;
            end
        endcase
        return o;
    endfunction

    state_e            state_q;
    state_e            state_d;
    outs_t             outs_q;
    logic [WORD_W-1:0] shift_q;
    logic [REM_W-1:0]  remaining_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  n_d;
    logic              take_word;

    // Next-state decode, word acceptance and per-word shift count.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d   = state_q;
        take_word = 1'b0;
        n_d       = CNT_WORD;

        // n = min(WORD_W, remaining): the last word may be only partly used
        if (32'(remaining_q) < WORD_W_U) begin
            n_d = CNT_W'(remaining_q);
        end

        case (state_q)
            S_IDLE: begin
                // start beats a simultaneous abort; abort is ignored here
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // abort also masks word_ready, so no word is taken this cycle
                if (abort) begin
                    state_d = S_IDLE;
                end else if (word_valid) begin
                    state_d   = S_SHIFT;
                    take_word = 1'b1;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = (remaining_q == REM_ONE) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                // a pending done pulse always completes, abort or not
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, registered output flags and the shift datapath.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            // NOTE: every flop here, data path included, is cleared so a reset mid-load leaves no stale bits.
            state_q     <= S_IDLE;
            outs_q      <= '0;
            shift_q     <= '0;
            remaining_q <= '0;
            cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            outs_q  <= decode_outs(state_d);

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        remaining_q <= REM_FULL;
                    end
                end
                S_LOAD: begin
                    if (take_word) begin
                        shift_q <= word_data;
                        cnt_q   <= n_d;
                    end
                end
                S_SHIFT: begin
                    shift_q <= shift_q >> 1;
                    // both counters saturate at zero rather than wrap
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                    if (remaining_q != '0) begin
                        remaining_q <= remaining_q - REM_ONE;
                    end
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

    // word_ready drops combinationally with abort so an aborted cycle never
    // completes a handshake.
    assign word_ready = outs_q.ready & ~abort;
    assign chain_en   = outs_q.en;
    assign chain_se   = outs_q.en;
    // The data bit is only meaningful while shifting; elsewhere it is held low.
    assign chain_si   = outs_q.en & shift_q[0];
    assign busy       = outs_q.busy;
    assign done       = outs_q.done;

    // While shifting both counters are non-zero, so neither can underflow.
    a_shift_counts: assert property (@(posedge CK) disable iff (RST)
        (state_q == S_SHIFT) |-> (cnt_q != '0 && remaining_q != '0));

    // The chain is only clocked as part of a load.
    a_en_busy: assert property (@(posedge CK) disable iff (RST)
        chain_en |-> busy);

    // done is a single-cycle pulse.
    a_done_pulse: assert property (@(posedge CK) disable iff (RST)
        done |=> !done);

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader. Three instances: index 0 is CHAIN_LEN=20,
// index 1 is CHAIN_LEN=16, index 2 is CHAIN_LEN=1, all with WORD_W=8.
// Stimulus pushes the expected done cycle, chain_en total and final chain
// contents into a per-instance queue; a negedge monitor models each chain
// and pops/compares whenever done is seen.
module tb_ccff_chain_loader;

    typedef struct {
        int          done_cyc;
        int          en_exp;
        int          en_base;
        logic [19:0] chain_exp;
    } exp_t;

    logic CK  = 1'b0;
    logic RST = 1'b0;

    logic       start_s [3];
    logic       abort_s [3];
    logic       valid_s [3];
    logic [7:0] data_s  [3];
    logic       ready_s [3];
    logic       en_s    [3];
    logic       se_s    [3];
    logic       si_s    [3];
    logic       busy_s  [3];
    logic       done_s  [3];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          en_tot   [3];
    logic [19:0] chain_m  [3];
    exp_t        sb       [3][$];
    int          lens     [3] = '{20, 16, 1};

    always #5 CK = ~CK;

    always @(posedge CK) cyc++;

    ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut_a (
        .CK(CK), .RST(RST), .start(start_s[0]), .abort(abort_s[0]),
        .word_valid(valid_s[0]), .word_data(data_s[0]), .word_ready(ready_s[0]),
        .chain_en(en_s[0]), .chain_se(se_s[0]), .chain_si(si_s[0]),
        .busy(busy_s[0]), .done(done_s[0])
    );

    ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut_b (
        .CK(CK), .RST(RST), .start(start_s[1]), .abort(abort_s[1]),
        .word_valid(valid_s[1]), .word_data(data_s[1]), .word_ready(ready_s[1]),
        .chain_en(en_s[1]), .chain_se(se_s[1]), .chain_si(si_s[1]),
        .busy(busy_s[1]), .done(done_s[1])
    );

    ccff_chain_loader #(.CHAIN_LEN(1), .WORD_W(8)) dut_c (
        .CK(CK), .RST(RST), .start(start_s[2]), .abort(abort_s[2]),
        .word_valid(valid_s[2]), .word_data(data_s[2]), .word_ready(ready_s[2]),
        .chain_en(en_s[2]), .chain_se(se_s[2]), .chain_si(si_s[2]),
        .busy(busy_s[2]), .done(done_s[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] outs_of(input int d);
        return {ready_s[d], en_s[d], se_s[d], si_s[d], busy_s[d], done_s[d]};
    endfunction

    function automatic logic [19:0] chain_mask(input int d);
        if (lens[d] >= 20) return '1;
        return (20'd1 << lens[d]) - 20'd1;
    endfunction

    // Chain model (head at bit 0, shifts toward the tail) and scoreboard.
    always @(negedge CK) begin : monitor
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (en_s[d]) begin
                chain_m[d] = {chain_m[d][18:0], si_s[d]};
                en_tot[d]++;
            end
            if (done_s[d]) begin
                if (sb[d].size() == 0) begin
                    check($sformatf("dut%0d_unexpected_done", d), 32'(done_s[d]), 32'd0);
                end else begin
                    e = sb[d].pop_front();
                    check($sformatf("dut%0d_done_cycle", d), cyc, e.done_cyc);
                    check($sformatf("dut%0d_en_count", d), en_tot[d] - e.en_base, e.en_exp);
                    check($sformatf("dut%0d_chain", d), 32'(chain_m[d] & chain_mask(d)),
                          32'(e.chain_exp));
                end
            end else if (sb[d].size() != 0 && cyc > sb[d][0].done_cyc) begin
                e = sb[d].pop_front();
                check($sformatf("dut%0d_done_missing", d), 32'(done_s[d]), 32'd1);
            end
        end
    end

    // Pulse start for one edge; optionally queue the expected load result.
    // Cycle 1 is the period right after the start edge.
    task automatic do_start(input int d, input bit expect_done, input int done_cycle,
                            input int en_exp, input logic [19:0] chain_exp);
        exp_t e;
        @(negedge CK);
        start_s[d] = 1'b1;
        @(posedge CK);
        #1;
        start_s[d] = 1'b0;
        if (expect_done) begin
            e.done_cyc  = cyc + done_cycle - 1;
            e.en_exp    = en_exp;
            e.en_base   = en_tot[d];
            e.chain_exp = chain_exp;
            sb[d].push_back(e);
        end
    endtask

    // Wait (bounded) for a handshake with valid already high, then step past it.
    task automatic wait_handshake(input int d);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge CK);
            seen = ready_s[d] && valid_s[d];
        end
        check($sformatf("dut%0d_handshake", d), 32'(seen), 32'd1);
        @(posedge CK);
        #1;
    endtask

    // Present up to three words; with stall>0, valid is held low for that many
    // LOAD cycles before each word, and the chain must not move meanwhile.
    task automatic send_words(input int d, input int nw, input logic [7:0] w0,
                              input logic [7:0] w1, input logic [7:0] w2, input int stall);
        logic [19:0] snap;
        int          en_snap;
        bit          seen;
        for (int i = 0; i < nw; i++) begin
            data_s[d] = (i == 0) ? w0 : (i == 1) ? w1 : w2;
            if (stall > 0) begin
                valid_s[d] = 1'b0;
                seen = 1'b0;
                for (int k = 0; k < 100 && !seen; k++) begin
                    @(negedge CK);
                    seen = ready_s[d];
                end
                check($sformatf("dut%0d_stall_load", d), 32'(seen), 32'd1);
                snap    = chain_m[d];
                en_snap = en_tot[d];
                repeat (stall) @(posedge CK);
                #1;
                check($sformatf("dut%0d_stall_chain", d), 32'(chain_m[d]), 32'(snap));
                check($sformatf("dut%0d_stall_en", d), en_tot[d], en_snap);
            end
            valid_s[d] = 1'b1;
            wait_handshake(d);
        end
        valid_s[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        for (int k = 0; k < 300 && sb[d].size() != 0; k++) @(negedge CK);
        check($sformatf("dut%0d_drain", d), sb[d].size(), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int en_snap;
        for (int d = 0; d < 3; d++) begin
            start_s[d] = 1'b0;
            abort_s[d] = 1'b0;
            valid_s[d] = 1'b0;
            data_s[d]  = 8'h00;
            en_tot[d]  = 0;
            chain_m[d] = '0;
        end

        // Reset values
        #1 RST = 1'b1;
        #2;
        for (int d = 0; d < 3; d++) check($sformatf("dut%0d_reset_outs", d), 32'(outs_of(d)), 32'd0);
        repeat (3) @(posedge CK);
        @(negedge CK);
        RST = 1'b0;

        // Basic load, with a start pulse during SHIFT that must be ignored
        do_start(0, 1'b1, 24, 20, 20'hA53C6);
        fork
            send_words(0, 3, 8'hA5, 8'h3C, 8'hF6, 0);
            begin
                repeat (4) @(negedge CK);
                start_s[0] = 1'b1;
                @(negedge CK);
                start_s[0] = 1'b0;
            end
        join
        drain(0);
        repeat (5) @(posedge CK);

        // Abort on the 3rd SHIFT cycle of word 2
        do_start(0, 1'b0, 0, 0, '0);
        en_snap    = en_tot[0];
        data_s[0]  = 8'hA5;
        valid_s[0] = 1'b1;
        wait_handshake(0);
        data_s[0] = 8'h3C;
        wait_handshake(0);
        valid_s[0] = 1'b0;
        repeat (2) @(posedge CK);
        #1;
        abort_s[0] = 1'b1;
        @(posedge CK);
        #1;
        abort_s[0] = 1'b0;
        check("abort_outs_idle", 32'(outs_of(0)), 32'd0);
        check("abort_en_total", en_tot[0] - en_snap, 32'd11);
        repeat (30) @(posedge CK);

        // Abort in LOAD with a word presented the same cycle: not accepted
        do_start(0, 1'b0, 0, 0, '0);
        en_snap    = en_tot[0];
        data_s[0]  = 8'hFF;
        valid_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        #1;
        check("abort_load_ready", 32'(ready_s[0]), 32'd0);
        @(posedge CK);
        #1;
        abort_s[0] = 1'b0;
        valid_s[0] = 1'b0;
        check("abort_load_busy", 32'(busy_s[0]), 32'd0);
        repeat (3) @(posedge CK);
        #1;
        check("abort_load_no_shift", en_tot[0] - en_snap, 32'd0);

        // Full load after abort; upper nibble of 0x95 must be dropped
        do_start(0, 1'b1, 24, 20, 20'hF00FA);
        send_words(0, 3, 8'h0F, 8'hF0, 8'h95, 0);
        drain(0);

        // Source stalls: 5 idle LOAD cycles before each word, 15 cycles later
        do_start(0, 1'b1, 39, 20, 20'hA53C6);
        send_words(0, 3, 8'hA5, 8'h3C, 8'hF6, 5);
        drain(0);

        // Reset mid-SHIFT, then a full reload
        do_start(0, 1'b0, 0, 0, '0);
        data_s[0]  = 8'h5A;
        valid_s[0] = 1'b1;
        wait_handshake(0);
        valid_s[0] = 1'b0;
        repeat (3) @(posedge CK);
        #3 RST = 1'b1;
        #1;
        check("rst_mid_outs", 32'(outs_of(0)), 32'd0);
        en_snap = en_tot[0];
        repeat (3) @(posedge CK);
        @(negedge CK);
        RST = 1'b0;
        repeat (3) @(posedge CK);
        #1;
        check("rst_mid_no_en", en_tot[0] - en_snap, 32'd0);
        do_start(0, 1'b1, 24, 20, 20'hF00FA);
        send_words(0, 3, 8'h0F, 8'hF0, 8'h95, 0);
        drain(0);

        // Exact multiple: 16 bits in two 8-bit words
        do_start(1, 1'b1, 19, 16, 20'h0482C);
        send_words(1, 2, 8'h12, 8'h34, 8'h00, 0);
        drain(1);

        // Single-flop chain: only bit 0 of the word is used
        do_start(2, 1'b1, 3, 1, 20'h00001);
        send_words(2, 1, 8'h03, 8'h00, 8'h00, 0);
        drain(2);

        repeat (5) @(posedge CK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
